memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter that shares the single external memory bus (16-bit address, 16-bit read data, 16-bit write data, write strobe) between two requesters. Requester 0 is the CPU core. Requester 1 is a secondary master such as a program loader or DMA engine. The block sits between the masters and the memory. It runs one transaction at a time, picks a winner by round-robin, drives the memory bus from registers, and returns read data after a fixed memory latency.

## Interface
- ADDR_WIDTH, 16, address width of requesters and memory bus
- DATA_WIDTH, 16, data width of requesters and memory bus
- READ_LATENCY, 1, cycles from address on the bus to valid read data on aMemData; legal range 1..4
- aClock  input  1  clock, all logic on rising edge
- aReset  input  1  synchronous, active-high reset
- aRequest0 / aRequest1  input  1  transaction request, held until granted
- aWrite0 / aWrite1  input  1  1 = write, 0 = read; sampled with the request
- anAddress0 / anAddress1  input  ADDR_WIDTH  transaction address
- aWriteData0 / aWriteData1  input  DATA_WIDTH  write data
- anOutGrant0 / anOutGrant1  output  1  one-cycle pulse: request accepted and issued to memory
- anOutReadData  output  DATA_WIDTH  read data, shared by both requesters
- anOutReadValid0 / anOutReadValid1  output  1  one-cycle pulse: anOutReadData belongs to this requester
- anOutMemAddress  output  ADDR_WIDTH  memory address
- anOutMemData  output  DATA_WIDTH  memory write data
- anOutMemWrite  output  1  memory write strobe
- aMemData  input  DATA_WIDTH  memory read data

## Operation
- Every output is a register. Reset value of every output is 0.
- Reset puts the state in IDLE, gives the priority pointer to requester 0, and clears the latency counter.
- States:
  - IDLE: sample the requests.
    - No request: stay in IDLE.
    - One request: grant it.
    - Both requests: grant the requester named by the priority pointer.
    - On grant: latch that requester's write flag, address and data onto the memory bus registers. Pulse its grant. Move the pointer to the other requester, even when only one was requesting. Go to ISSUE.
  - ISSUE: the bus is driven for this cycle, and anOutMemWrite = latched write flag.
    - Write: go to IDLE.
    - Read: load the counter with READ_LATENCY and go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, capture aMemData into anOutReadData. Pulse the matching anOutReadValidN. Go to IDLE.
- Bus hold and strobe rules:
  - anOutMemAddress and anOutMemData hold their last values outside ISSUE.
  - anOutMemWrite is high only during the ISSUE cycle of a write.
  - anOutReadData holds its last captured value.
- Grants and read-valids are never asserted to both requesters in the same cycle.
- At most one transaction is in flight. Requests arriving in ISSUE or WAIT are ignored until the next IDLE.
- A requester may drop its request the cycle after its grant.
- If a request is dropped before grant, the transaction never happens. There is no error flag.

## Timing
- Edge E samples a request in IDLE.
- Cycle after E, the ISSUE cycle C:
  - anOutGrantN = 1.
  - anOutMemAddress, anOutMemData and anOutMemWrite are valid.
- Memory presents read data in cycle C+READ_LATENCY. The arbiter registers it at the end of that cycle.
- anOutReadData and anOutReadValidN are asserted in cycle C+READ_LATENCY+1 for one cycle. The state is IDLE in that same cycle.
- Throughput:
  - Write occupies 2 cycles (IDLE + ISSUE).
  - Read occupies READ_LATENCY+2 cycles, from the request-sampled IDLE cycle to the read-valid cycle.
- Reset has priority over every state.
  - Reset during WAIT aborts the read: no read-valid pulse, and aMemData is not captured.
  - Reset during ISSUE drops anOutMemWrite in the next cycle. The write may already have reached memory; this is acceptable.
- If both requests are held continuously, grants alternate 0,1,0,1… starting with 0 after reset.
- If the same requester requests continuously and the other is idle, it is granted every transaction.

## Test plan
- Read, requester 0 alone, READ_LATENCY=1:
  - Stimulus: anAddress0=0x0400 with memory returning 0xBEEF.
  - Required: grant0 in C, anOutMemAddress=0x0400 in C, then anOutReadData=0xBEEF with anOutReadValid0=1 in C+2. anOutReadValid1 stays 0.
- Write, requester 1:
  - Stimulus: anAddress1=0x0010, aWriteData1=0x1234.
  - Required: grant1 and anOutMemWrite=1 in exactly one cycle with address 0x0010 and data 0x1234. No read-valid pulse. Next request is granted 2 cycles after the previous one.
- Contention:
  - Stimulus: both requesters hold read requests for four transactions.
  - Required: grants in order 0,1,0,1. Each read-valid goes to the matching requester with its own data.
- Latency parameter:
  - Stimulus: READ_LATENCY=3, read of 0x0055 returning 0xA5A5 in C+3.
  - Required: anOutReadValid0 in C+4, and request in IDLE to read-valid spans 5 cycles.
- Reset mid-read:
  - Stimulus: aReset asserted during WAIT.
  - Required: all outputs 0 the next cycle and no read-valid pulse. The next simultaneous request pair is granted to requester 0 first.
- Back-to-back:
  - Stimulus: requester 1 alone issues a write then a read.
  - Required: both granted with no idle gap beyond the IDLE sampling cycle, and the pointer toggles each time.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Requester and memory bus signals shared by the two masters and the arbiter.
// The slave modport is the arbiter's view; master is the view of the masters and memory.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  aRequest0;
    logic                  aRequest1;
    logic                  aWrite0;
    logic                  aWrite1;
    logic [ADDR_WIDTH-1:0] anAddress0;
    logic [ADDR_WIDTH-1:0] anAddress1;
    logic [DATA_WIDTH-1:0] aWriteData0;
    logic [DATA_WIDTH-1:0] aWriteData1;
    logic                  anOutGrant0;
    logic                  anOutGrant1;
    logic [DATA_WIDTH-1:0] anOutReadData;
    logic                  anOutReadValid0;
    logic                  anOutReadValid1;
    logic [ADDR_WIDTH-1:0] anOutMemAddress;
    logic [DATA_WIDTH-1:0] anOutMemData;
    logic                  anOutMemWrite;
    logic [DATA_WIDTH-1:0] aMemData;

    modport slave (
        input  aRequest0, aRequest1, aWrite0, aWrite1,
        input  anAddress0, anAddress1, aWriteData0, aWriteData1, aMemData,
        output anOutGrant0, anOutGrant1, anOutReadData,
        output anOutReadValid0, anOutReadValid1,
        output anOutMemAddress, anOutMemData, anOutMemWrite
    );

    modport master (
        output aRequest0, aRequest1, aWrite0, aWrite1,
        output anAddress0, anAddress1, aWriteData0, aWriteData1, aMemData,
        input  anOutGrant0, anOutGrant1, anOutReadData,
        input  anOutReadValid0, anOutReadValid1,
        input  anOutMemAddress, anOutMemData, anOutMemWrite
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory bus between two masters, one
// transaction at a time, with registered outputs and fixed read latency.
module memory_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input logic             aClock,
    input logic             aReset,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY);

    state_t                state, state_next;
    logic                  ptr, ptr_next;
    logic                  owner, owner_next;
    logic [2:0]            cnt, cnt_next;
    logic                  grant0, grant0_next;
    logic                  grant1, grant1_next;
    logic [ADDR_WIDTH-1:0] mem_addr, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_data, mem_data_next;
    logic                  mem_write, mem_write_next;
    logic [DATA_WIDTH-1:0] read_data, read_data_next;
    logic                  valid0, valid0_next;
    logic                  valid1, valid1_next;
    logic                  winner;

    // Pointer only decides ties; a lone requester always wins.
    assign winner = (bus.aRequest0 && bus.aRequest1) ? ptr : bus.aRequest1;

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        owner_next     = owner;
        cnt_next       = cnt;
        grant0_next    = 1'b0;
        grant1_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_data_next  = mem_data;
        mem_write_next = 1'b0;
        read_data_next = read_data;
        valid0_next    = 1'b0;
        valid1_next    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.aRequest0 || bus.aRequest1) begin
                    state_next     = ISSUE;
                    owner_next     = winner;
                    ptr_next       = ~winner;
                    grant0_next    = ~winner;
                    grant1_next    = winner;
                    mem_addr_next  = winner ? bus.anAddress1 : bus.anAddress0;
                    mem_data_next  = winner ? bus.aWriteData1 : bus.aWriteData0;
                    mem_write_next = winner ? bus.aWrite1 : bus.aWrite0;
                end
            end
            ISSUE: begin
                // The strobe register doubles as the latched write flag.
                if (mem_write) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    read_data_next = bus.aMemData;
                    valid0_next    = ~owner;
                    valid1_next    = owner;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aClock) begin
        if (aReset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            grant0    <= 1'b0;
            grant1    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_write <= 1'b0;
            read_data <= '0;
            valid0    <= 1'b0;
            valid1    <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            cnt       <= cnt_next;
            grant0    <= grant0_next;
            grant1    <= grant1_next;
            mem_addr  <= mem_addr_next;
            mem_data  <= mem_data_next;
            mem_write <= mem_write_next;
            read_data <= read_data_next;
            valid0    <= valid0_next;
            valid1    <= valid1_next;
        end
    end

    assign bus.anOutGrant0     = grant0;
    assign bus.anOutGrant1     = grant1;
    assign bus.anOutMemAddress = mem_addr;
    assign bus.anOutMemData    = mem_data;
    assign bus.anOutMemWrite   = mem_write;
    assign bus.anOutReadData   = read_data;
    assign bus.anOutReadValid0 = valid0;
    assign bus.anOutReadValid1 = valid1;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: one instance at read latency 1, one at latency 3,
// each behind a small read-only memory model; grants and reads are scoreboarded.
module tb_memory_arbiter;
    typedef struct packed {
        logic        req;
        logic [15:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic gq_a[$];
    logic gq_b[$];
    rd_t  rdq_a[$];
    rd_t  rdq_b[$];

    memory_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ifa ();
    memory_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ifb ();

    memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(1)) dut_a (
        .aClock(clk), .aReset(rst), .bus(ifa)
    );
    memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3)) dut_b (
        .aClock(clk), .aReset(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_value(input logic [15:0] a);
        case (a)
            16'h0400: return 16'hBEEF;
            16'h0055: return 16'hA5A5;
            default:  return a ^ 16'h3C3C;
        endcase
    endfunction

    // Memory returns data exactly READ_LATENCY cycles after the issue cycle, garbage otherwise.
    logic        pa_v = 1'b0;
    logic [15:0] pa_a = '0;
    logic [2:0]  pb_v = '0;
    logic [15:0] pb_a0 = '0, pb_a1 = '0, pb_a2 = '0;

    always @(posedge clk) begin
        pa_v  <= (ifa.anOutGrant0 | ifa.anOutGrant1) & ~ifa.anOutMemWrite;
        pa_a  <= ifa.anOutMemAddress;
        pb_v  <= {pb_v[1:0], (ifb.anOutGrant0 | ifb.anOutGrant1) & ~ifb.anOutMemWrite};
        pb_a0 <= ifb.anOutMemAddress;
        pb_a1 <= pb_a0;
        pb_a2 <= pb_a1;
    end

    assign ifa.aMemData = pa_v ? mem_value(pa_a) : 16'hDEAD;
    assign ifb.aMemData = pb_v[2] ? mem_value(pb_a2) : 16'hDEAD;

    task automatic monitor_a();
        logic g;
        rd_t  e;
        forever begin
            @(negedge clk);
            if (ifa.anOutGrant0 || ifa.anOutGrant1) begin
                total++;
                if (gq_a.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL grant_a: got g1g0=%b%b, required no grant", ifa.anOutGrant1, ifa.anOutGrant0);
                end else begin
                    g = gq_a.pop_front();
                    if ({ifa.anOutGrant1, ifa.anOutGrant0} !== {g, ~g}) begin
                        bad++;
                        $display("[TB] FAIL grant_a: got g1g0=%b%b, required %b%b", ifa.anOutGrant1, ifa.anOutGrant0, g, ~g);
                    end
                end
            end
            if (ifa.anOutReadValid0 || ifa.anOutReadValid1) begin
                total++;
                if (rdq_a.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL read_a: got v1v0=%b%b data=%h, required no read-valid", ifa.anOutReadValid1, ifa.anOutReadValid0, ifa.anOutReadData);
                end else begin
                    e = rdq_a.pop_front();
                    if ({ifa.anOutReadValid1, ifa.anOutReadValid0, ifa.anOutReadData} !== {e.req, ~e.req, e.data}) begin
                        bad++;
                        $display("[TB] FAIL read_a: got v1v0=%b%b data=%h, required %b%b data=%h", ifa.anOutReadValid1, ifa.anOutReadValid0, ifa.anOutReadData, e.req, ~e.req, e.data);
                    end
                end
            end
        end
    endtask

    task automatic monitor_b();
        logic g;
        rd_t  e;
        forever begin
            @(negedge clk);
            if (ifb.anOutGrant0 || ifb.anOutGrant1) begin
                total++;
                if (gq_b.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL grant_b: got g1g0=%b%b, required no grant", ifb.anOutGrant1, ifb.anOutGrant0);
                end else begin
                    g = gq_b.pop_front();
                    if ({ifb.anOutGrant1, ifb.anOutGrant0} !== {g, ~g}) begin
                        bad++;
                        $display("[TB] FAIL grant_b: got g1g0=%b%b, required %b%b", ifb.anOutGrant1, ifb.anOutGrant0, g, ~g);
                    end
                end
            end
            if (ifb.anOutReadValid0 || ifb.anOutReadValid1) begin
                total++;
                if (rdq_b.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL read_b: got v1v0=%b%b data=%h, required no read-valid", ifb.anOutReadValid1, ifb.anOutReadValid0, ifb.anOutReadData);
                end else begin
                    e = rdq_b.pop_front();
                    if ({ifb.anOutReadValid1, ifb.anOutReadValid0, ifb.anOutReadData} !== {e.req, ~e.req, e.data}) begin
                        bad++;
                        $display("[TB] FAIL read_b: got v1v0=%b%b data=%h, required %b%b data=%h", ifb.anOutReadValid1, ifb.anOutReadValid0, ifb.anOutReadData, e.req, ~e.req, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [52:0] outs_a, outs_b;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs_a = {ifa.anOutGrant0, ifa.anOutGrant1, ifa.anOutReadData, ifa.anOutReadValid0, ifa.anOutReadValid1, ifa.anOutMemAddress, ifa.anOutMemData, ifa.anOutMemWrite};
        outs_b = {ifb.anOutGrant0, ifb.anOutGrant1, ifb.anOutReadData, ifb.anOutReadValid0, ifb.anOutReadValid1, ifb.anOutMemAddress, ifb.anOutMemData, ifb.anOutMemWrite};
        total++;
        if (outs_a !== '0 || outs_b !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got a=%h b=%h, required 0", outs_a, outs_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read_single();
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b1; ifa.aWrite0 = 1'b0; ifa.anAddress0 = 16'h0400;
        gq_a.push_back(1'b0);
        rdq_a.push_back({1'b0, 16'hBEEF});
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({ifa.anOutGrant0, ifa.anOutReadValid0, ifa.anOutReadValid1} !== {(i == 0), (i == 2), 1'b0}) begin
                bad++;
                $display("[TB] FAIL read_single_timing: cycle C+%0d got g0 v0 v1=%b%b%b, required %b%b0", i, ifa.anOutGrant0, ifa.anOutReadValid0, ifa.anOutReadValid1, (i == 0), (i == 2));
            end
            if (i == 0) begin
                total++;
                if ({ifa.anOutMemAddress, ifa.anOutMemWrite} !== {16'h0400, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL read_single_bus: got addr=%h wr=%b, required 0400 0", ifa.anOutMemAddress, ifa.anOutMemWrite);
                end
            end
            if (i == 2) begin
                total++;
                if (ifa.anOutReadData !== 16'hBEEF) begin
                    bad++;
                    $display("[TB] FAIL read_single_data: got %h, required beef", ifa.anOutReadData);
                end
            end
        end
    endtask

    task automatic test_write();
        logic exp;
        @(posedge clk); #1;
        ifa.aRequest1 = 1'b1; ifa.aWrite1 = 1'b1; ifa.anAddress1 = 16'h0010; ifa.aWriteData1 = 16'h1234;
        gq_a.push_back(1'b1);
        gq_a.push_back(1'b1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 2) ifa.aRequest1 = 1'b0;
            @(negedge clk);
            exp = (i % 2 == 0);
            total++;
            if ({ifa.anOutGrant0, ifa.anOutGrant1, ifa.anOutMemWrite, ifa.anOutReadValid0, ifa.anOutReadValid1} !== {1'b0, exp, exp, 2'b00}) begin
                bad++;
                $display("[TB] FAIL write_timing: cycle C+%0d got g0 g1 wr v0 v1=%b%b%b%b%b, required 0%b%b00", i, ifa.anOutGrant0, ifa.anOutGrant1, ifa.anOutMemWrite, ifa.anOutReadValid0, ifa.anOutReadValid1, exp, exp);
            end
            if (exp) begin
                total++;
                if ({ifa.anOutMemAddress, ifa.anOutMemData} !== {16'h0010, 16'h1234}) begin
                    bad++;
                    $display("[TB] FAIL write_bus: got addr=%h data=%h, required 0010 1234", ifa.anOutMemAddress, ifa.anOutMemData);
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic test_contention();
        int grants = 0;
        int valids = 0;
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b1; ifa.aWrite0 = 1'b0; ifa.anAddress0 = 16'h0100;
        ifa.aRequest1 = 1'b1; ifa.aWrite1 = 1'b0; ifa.anAddress1 = 16'h0200;
        for (int k = 0; k < 2; k++) begin
            gq_a.push_back(1'b0);
            gq_a.push_back(1'b1);
            rdq_a.push_back({1'b0, mem_value(16'h0100)});
            rdq_a.push_back({1'b1, mem_value(16'h0200)});
        end
        for (int i = 0; i < 40 && valids < 4; i++) begin
            @(negedge clk);
            if (ifa.anOutGrant0 || ifa.anOutGrant1) grants++;
            if (grants >= 4) begin
                ifa.aRequest0 = 1'b0;
                ifa.aRequest1 = 1'b0;
            end
            if (ifa.anOutReadValid0 || ifa.anOutReadValid1) valids++;
        end
        total++;
        if (valids != 4) begin
            bad++;
            $display("[TB] FAIL contention_reads: got %0d read-valids, required 4", valids);
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        ifb.aRequest0 = 1'b1; ifb.aWrite0 = 1'b0; ifb.anAddress0 = 16'h0055;
        gq_b.push_back(1'b0);
        rdq_b.push_back({1'b0, 16'hA5A5});
        @(posedge clk); #1;
        ifb.aRequest0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({ifb.anOutGrant0, ifb.anOutReadValid0, ifb.anOutReadValid1} !== {(i == 0), (i == 4), 1'b0}) begin
                bad++;
                $display("[TB] FAIL latency_timing: cycle C+%0d got g0 v0 v1=%b%b%b, required %b%b0", i, ifb.anOutGrant0, ifb.anOutReadValid0, ifb.anOutReadValid1, (i == 0), (i == 4));
            end
            if (i == 4) begin
                total++;
                if (ifb.anOutReadData !== 16'hA5A5) begin
                    bad++;
                    $display("[TB] FAIL latency_data: got %h, required a5a5", ifb.anOutReadData);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [52:0] outs;
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b1; ifa.aWrite0 = 1'b0; ifa.anAddress0 = 16'h0300;
        gq_a.push_back(1'b0);
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        outs = {ifa.anOutGrant0, ifa.anOutGrant1, ifa.anOutReadData, ifa.anOutReadValid0, ifa.anOutReadValid1, ifa.anOutMemAddress, ifa.anOutMemData, ifa.anOutMemWrite};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_read_outputs: got %h, required 0", outs);
        end
        @(negedge clk);
        total++;
        if ({ifa.anOutReadValid0, ifa.anOutReadValid1} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_mid_read_valid: got v0v1=%b%b, required 00", ifa.anOutReadValid0, ifa.anOutReadValid1);
        end
    endtask

    task automatic test_pair_priority(input logic [15:0] addr0, input logic [15:0] addr1);
        int grants = 0;
        int valids = 0;
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b1; ifa.aWrite0 = 1'b0; ifa.anAddress0 = addr0;
        ifa.aRequest1 = 1'b1; ifa.aWrite1 = 1'b0; ifa.anAddress1 = addr1;
        gq_a.push_back(1'b0);
        gq_a.push_back(1'b1);
        rdq_a.push_back({1'b0, mem_value(addr0)});
        rdq_a.push_back({1'b1, mem_value(addr1)});
        for (int i = 0; i < 30 && valids < 2; i++) begin
            @(negedge clk);
            if (ifa.anOutGrant0 || ifa.anOutGrant1) begin
                if (grants == 0) begin
                    total++;
                    if (ifa.anOutGrant0 !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL pair_first_grant: got g0g1=%b%b, required 10", ifa.anOutGrant0, ifa.anOutGrant1);
                    end
                end
                grants++;
            end
            if (grants >= 2) begin
                ifa.aRequest0 = 1'b0;
                ifa.aRequest1 = 1'b0;
            end
            if (ifa.anOutReadValid0 || ifa.anOutReadValid1) valids++;
        end
        total++;
        if (valids != 2) begin
            bad++;
            $display("[TB] FAIL pair_reads: got %0d read-valids, required 2", valids);
        end
    endtask

    task automatic test_back_to_back();
        logic expg;
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b1; ifa.aWrite0 = 1'b0; ifa.anAddress0 = 16'h0900;
        gq_a.push_back(1'b0);
        rdq_a.push_back({1'b0, mem_value(16'h0900)});
        @(posedge clk); #1;
        ifa.aRequest0 = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        ifa.aRequest1 = 1'b1; ifa.aWrite1 = 1'b1; ifa.anAddress1 = 16'h0020; ifa.aWriteData1 = 16'h5678;
        gq_a.push_back(1'b1);
        gq_a.push_back(1'b1);
        rdq_a.push_back({1'b1, mem_value(16'h0030)});
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i == 0) begin
                ifa.aWrite1 = 1'b0;
                ifa.anAddress1 = 16'h0030;
            end
            if (i == 2) ifa.aRequest1 = 1'b0;
            @(negedge clk);
            expg = (i == 0) || (i == 2);
            total++;
            if ({ifa.anOutGrant0, ifa.anOutGrant1, ifa.anOutMemWrite, ifa.anOutReadValid1} !== {1'b0, expg, (i == 0), (i == 4)}) begin
                bad++;
                $display("[TB] FAIL back_to_back_timing: cycle C+%0d got g0 g1 wr v1=%b%b%b%b, required 0%b%b%b", i, ifa.anOutGrant0, ifa.anOutGrant1, ifa.anOutMemWrite, ifa.anOutReadValid1, expg, (i == 0), (i == 4));
            end
            if (i == 0 || i == 2) begin
                total++;
                if (ifa.anOutMemAddress !== ((i == 0) ? 16'h0020 : 16'h0030)) begin
                    bad++;
                    $display("[TB] FAIL back_to_back_addr: cycle C+%0d got %h, required %h", i, ifa.anOutMemAddress, (i == 0) ? 16'h0020 : 16'h0030);
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic test_drain();
        repeat (6) @(negedge clk);
        total++;
        if (gq_a.size() + gq_b.size() + rdq_a.size() + rdq_b.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d outstanding expectations, required 0", gq_a.size() + gq_b.size() + rdq_a.size() + rdq_b.size());
        end
    endtask

    initial begin
        ifa.aRequest0 = 1'b0; ifa.aRequest1 = 1'b0; ifa.aWrite0 = 1'b0; ifa.aWrite1 = 1'b0;
        ifa.anAddress0 = '0; ifa.anAddress1 = '0; ifa.aWriteData0 = '0; ifa.aWriteData1 = '0;
        ifb.aRequest0 = 1'b0; ifb.aRequest1 = 1'b0; ifb.aWrite0 = 1'b0; ifb.aWrite1 = 1'b0;
        ifb.anAddress0 = '0; ifb.anAddress1 = '0; ifb.aWriteData0 = '0; ifb.aWriteData1 = '0;
        fork
            monitor_a();
            monitor_b();
        join_none
        test_reset();
        test_read_single();
        test_write();
        test_contention();
        test_latency();
        test_reset_mid_read();
        test_pair_priority(16'h0700, 16'h0800);
        test_back_to_back();
        test_pair_priority(16'h0A00, 16'h0B00);
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test by 200000, required earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
